// File: rtl/dmem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_access_unit_pkg
//  Brief    : Shared size codes, FSM encoding and alignment helper for the
//             data-memory access unit.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_access_unit_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Size code 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic r;
        case (size)
            MEM_BYTE: r = 1'b0;
            MEM_HALF: r = addr_lo[0];
            default:  r = |addr_lo;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_bus_if
//  Brief    : req/ack data-memory bus between the access unit and memory.
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_bus_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_access_unit_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : memLaneAlign
//  Brief    : Byte-lane replication/strobes for stores and right-justification
//             of loaded words, from access size and address low bits.
//  Revision : 1.0  initial release
// ============================================================================
module memLaneAlign
    import dmem_access_unit_pkg::*;
(
    input  wire logic [1:0]  i_size,
    input  wire logic [1:0]  i_addr_lo,
    input  wire logic [31:0] i_wdata,
    input  wire logic [31:0] i_rdata,
    output logic      [3:0]  o_wstrb,
    output logic      [31:0] o_wdata,
    output logic      [31:0] o_rdata
);

    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
        case (i_size)
            MEM_BYTE: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            MEM_HALF: begin
                o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_wstrb = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    assign o_rdata = i_rdata >> {i_addr_lo, 3'b000};

endmodule
`default_nettype wire

// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_access_unit
//  Brief    : MEM-stage bridge to a variable-latency req/ack data memory with
//             pipeline stall, misalignment and bus-timeout reporting.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic [31:0] Mi_addr,
    input  wire logic [31:0] Mi_writeData,
    input  wire logic [1:0]  Mi_memSize,
    input  wire logic        Mi_memRead,
    input  wire logic        Mi_memWrite,
    output logic      [31:0] Mo_readData,
    output logic             Mo_stall,
    output logic             Mo_misaligned,
    output logic             Mo_busError,
    dmem_bus_if.master       mem_bus
);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_read_data;
    logic        r_bus_error;

    logic        w_access;
    logic        w_mis;
    logic        w_start;
    logic [7:0]  w_cnt_next;
    logic        w_timeout;
    logic [1:0]  w_lane_lo;
    logic [3:0]  w_lane_wstrb;
    logic [31:0] w_lane_wdata;
    logic [31:0] w_lane_rdata;

    assign w_access   = Mi_memRead | Mi_memWrite;
    assign w_mis      = is_misaligned(Mi_memSize, Mi_addr[1:0]);
    assign w_start    = (r_state == IDLE) & w_access & ~w_mis;
    assign w_cnt_next = r_cnt + 8'd1;
    assign w_timeout  = (w_cnt_next == 8'(TIMEOUT));

    // Store lanes come from the live MEM inputs; the load shift uses the
    // address latched at request time since the bus owns the access by then.
    assign w_lane_lo = (r_state == IDLE) ? Mi_addr[1:0] : r_addr_lo;

    memLaneAlign u_lane_align (
        .i_size    (Mi_memSize),
        .i_addr_lo (w_lane_lo),
        .i_wdata   (Mi_writeData),
        .i_rdata   (mem_bus.mem_rdata),
        .o_wstrb   (w_lane_wstrb),
        .o_wdata   (w_lane_wdata),
        .o_rdata   (w_lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wstrb     <= 4'd0;
            r_wdata     <= 32'd0;
            r_addr_lo   <= 2'd0;
            r_read_data <= 32'd0;
            r_bus_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_bus_error <= 1'b0;
                    if (w_start) begin
                        r_state   <= BUSY;
                        r_cnt     <= 8'd0;
                        r_req     <= 1'b1;
                        r_we      <= Mi_memWrite;
                        r_addr    <= {Mi_addr[31:2], 2'b00};
                        r_wstrb   <= Mi_memWrite ? w_lane_wstrb : 4'd0;
                        r_wdata   <= Mi_memWrite ? w_lane_wdata : 32'd0;
                        r_addr_lo <= Mi_addr[1:0];
                    end
                end
                BUSY: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (mem_bus.mem_ack) begin
                        r_req       <= 1'b0;
                        r_read_data <= r_we ? 32'd0 : w_lane_rdata;
                        r_state     <= DONE;
                    end else if (w_timeout) begin
                        r_cnt       <= w_cnt_next;
                        r_req       <= 1'b0;
                        r_bus_error <= 1'b1;
                        r_read_data <= 32'd0;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                DONE: begin
                    r_bus_error <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Mo_stall      = ~reset & (w_start | (r_state == BUSY));
    assign Mo_misaligned = (r_state == IDLE) & w_access & w_mis;
    assign Mo_readData   = r_read_data;
    assign Mo_busError   = r_bus_error;

    assign mem_bus.mem_req   = r_req;
    assign mem_bus.mem_we    = r_we;
    assign mem_bus.mem_addr  = r_addr;
    assign mem_bus.mem_wstrb = r_wstrb;
    assign mem_bus.mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_access_unit
//  Brief    : Scoreboard bench for dmem_access_unit with a pipeline-style
//             driver, a scripted memory responder and an output monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_access_unit;
    import dmem_access_unit_pkg::*;

    localparam int TMO = 4;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        chk_wdata;
    } req_t;

    typedef struct {
        int          issue;
        int          lat;
        logic [31:0] rdata;
        logic        berr;
    } done_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Mi_addr;
    logic [31:0] Mi_writeData;
    logic [1:0]  Mi_memSize;
    logic        Mi_memRead;
    logic        Mi_memWrite;
    logic [31:0] Mo_readData;
    logic        Mo_stall;
    logic        Mo_misaligned;
    logic        Mo_busError;

    dmem_bus_if bus ();

    dmem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .reset         (reset),
        .Mi_addr       (Mi_addr),
        .Mi_writeData  (Mi_writeData),
        .Mi_memSize    (Mi_memSize),
        .Mi_memRead    (Mi_memRead),
        .Mi_memWrite   (Mi_memWrite),
        .Mo_readData   (Mo_readData),
        .Mo_stall      (Mo_stall),
        .Mo_misaligned (Mo_misaligned),
        .Mo_busError   (Mo_busError),
        .mem_bus       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    req_t  req_q[$];
    done_t done_q[$];
    int    mis_q[$];

    int          ack_at_v  = -1;
    logic [31:0] rdata_v   = 32'd0;
    bit          stray_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Memory model: acks on the ack_at_v-th cycle of an outstanding request.
    initial begin
        int busy_cyc;
        busy_cyc = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_req) begin
                busy_cyc++;
                bus.mem_ack = (busy_cyc == ack_at_v);
            end else begin
                busy_cyc = 0;
                bus.mem_ack = stray_ack;
            end
            bus.mem_rdata = rdata_v;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request,
    // completion or misalignment flag.
    initial begin
        bit          prev_stall;
        bit          prev_req;
        bit          done_ev;
        logic [68:0] snap;
        req_t        e;
        done_t       d;
        int          m;
        prev_stall = 1'b0;
        prev_req   = 1'b0;
        snap       = '0;
        forever begin
            @(negedge clk);
            done_ev = prev_stall && !Mo_stall && !reset;
            if (bus.mem_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    flag("req", "unexpected bus request");
                end else begin
                    e = req_q.pop_front();
                    chk("req_addr", bus.mem_addr, e.addr);
                    chk("req_we", 32'(bus.mem_we), 32'(e.we));
                    chk("req_wstrb", 32'(bus.mem_wstrb), 32'(e.wstrb));
                    if (e.chk_wdata) chk("req_wdata", bus.mem_wdata, e.wdata);
                    chk("req_stall", 32'(Mo_stall), 32'd1);
                end
                snap = {bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata};
            end else if (bus.mem_req && prev_req) begin
                if ({bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata} !== snap)
                    flag("busy_stable", "bus fields changed while request pending");
            end
            if (done_ev) begin
                if (done_q.size() == 0) begin
                    flag("done", "unexpected completion");
                end else begin
                    d = done_q.pop_front();
                    chk("done_latency", 32'(cyc - d.issue), 32'(d.lat));
                    chk("done_rdata", Mo_readData, d.rdata);
                    chk("done_busError", 32'(Mo_busError), 32'(d.berr));
                    chk("done_req", 32'(bus.mem_req), 32'd0);
                end
            end else if (Mo_busError === 1'b1) begin
                flag("busError_extra", "busError asserted outside DONE");
            end
            if (Mo_misaligned === 1'b1) begin
                if (mis_q.size() == 0) begin
                    flag("mis", "unexpected misaligned flag");
                end else begin
                    m = mis_q.pop_front();
                    chk("mis_cycle", 32'(cyc), 32'(m));
                    chk("mis_stall", 32'(Mo_stall), 32'd0);
                    chk("mis_req", 32'(bus.mem_req), 32'd0);
                end
            end
            prev_stall = (Mo_stall === 1'b1);
            prev_req   = (bus.mem_req === 1'b1);
        end
    end

    // Pipeline driver: called at posedge+1, holds the instruction while
    // stalled and retires it at the first edge where stall is low.
    task automatic run_op(
        input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
        input logic rd, input logic wr, input int ack_at, input logic [31:0] rdv,
        input logic mis, input logic [31:0] e_addr, input logic [3:0] e_strb,
        input logic [31:0] e_wdata, input logic [31:0] e_rdata, input logic e_berr,
        input int e_lat
    );
        int n;
        Mi_addr      = a;
        Mi_writeData = wd;
        Mi_memSize   = sz;
        Mi_memRead   = rd;
        Mi_memWrite  = wr;
        ack_at_v     = ack_at;
        rdata_v      = rdv;
        if (mis) begin
            mis_q.push_back(cyc);
        end else begin
            req_q.push_back('{e_addr, wr, e_strb, e_wdata, wr});
            done_q.push_back('{cyc, e_lat, e_rdata, e_berr});
        end
        n = 0;
        @(negedge clk);
        while (Mo_stall !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) flag("stall_bound", "stall never released");
        @(posedge clk);
        #1;
        Mi_memRead  = 1'b0;
        Mi_memWrite = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        Mi_addr      = 32'd0;
        Mi_writeData = 32'd0;
        Mi_memSize   = MEM_WORD;
        Mi_memRead   = 1'b1;
        Mi_memWrite  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_readData", Mo_readData, 32'd0);
        chk("rst_busError", 32'(Mo_busError), 32'd0);
        chk("rst_stall", 32'(Mo_stall), 32'd0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        Mi_memRead = 1'b0;
        @(posedge clk);
        #1;

        // sw, ack in 2nd busy cycle
        run_op(32'h100, 32'hDEADBEEF, MEM_WORD, 0, 1, 2, 32'h0, 0,
               32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 3);
        // sb at lane 3, immediate ack (back-to-back with previous)
        run_op(32'h203, 32'h12345678, MEM_BYTE, 0, 1, 1, 32'h0, 0,
               32'h200, 4'b1000, 32'h78787878, 32'h0, 0, 2);
        // lh upper half, ack coincides with the timeout count
        run_op(32'h102, 32'h0, MEM_HALF, 1, 0, 4, 32'hABCD1234, 0,
               32'h100, 4'b0000, 32'h0, 32'h0000ABCD, 0, 5);
        // misaligned lw and lh
        run_op(32'h101, 32'h0, MEM_WORD, 1, 0, -1, 32'h0, 1,
               32'h0, 4'h0, 32'h0, 32'h0, 0, 0);
        run_op(32'h003, 32'h0, MEM_HALF, 1, 0, -1, 32'h0, 1,
               32'h0, 4'h0, 32'h0, 32'h0, 0, 0);
        // sh upper half
        run_op(32'h006, 32'h0000BEEF, MEM_HALF, 0, 1, 1, 32'h0, 0,
               32'h004, 4'b1100, 32'hBEEFBEEF, 32'h0, 0, 2);
        // lb with a stray ack held outside the request window
        stray_ack = 1'b1;
        run_op(32'h201, 32'h0, MEM_BYTE, 1, 0, 3, 32'h11223344, 0,
               32'h200, 4'b0000, 32'h0, 32'h00112233, 0, 4);
        stray_ack = 1'b0;
        // read+write together: the store wins and loads nothing
        run_op(32'h001, 32'h000000AB, MEM_BYTE, 1, 1, 1, 32'hFFFFFFFF, 0,
               32'h000, 4'b0010, 32'hABABABAB, 32'h0, 0, 2);
        // timeout: no ack ever
        run_op(32'h300, 32'h0, MEM_WORD, 1, 0, -1, 32'hFFFFFFFF, 0,
               32'h300, 4'b0000, 32'h0, 32'h0, 1, 5);
        // 2'b11 treated as word
        run_op(32'h304, 32'h0, 2'b11, 1, 0, 2, 32'h55AA55AA, 0,
               32'h304, 4'b0000, 32'h0, 32'h55AA55AA, 0, 3);

        // reset pulsed during BUSY
        Mi_addr    = 32'h400;
        Mi_memSize = MEM_WORD;
        Mi_memRead = 1'b1;
        ack_at_v   = -1;
        req_q.push_back('{32'h400, 1'b0, 4'h0, 32'h0, 1'b0});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        Mi_memRead = 1'b0;
        @(negedge clk);
        chk("rstbusy_req", 32'(bus.mem_req), 32'd0);
        chk("rstbusy_stall", 32'(Mo_stall), 32'd0);
        @(posedge clk);
        #1;
        run_op(32'h404, 32'h0, MEM_WORD, 1, 0, 1, 32'h0BADF00D, 0,
               32'h404, 4'b0000, 32'h0, 32'h0BADF00D, 0, 2);
        run_op(32'h407, 32'h0, MEM_BYTE, 1, 0, 2, 32'h80FFFFFF, 0,
               32'h404, 4'b0000, 32'h0, 32'h00000080, 0, 3);

        repeat (3) @(posedge clk);
        chk("req_q_empty", 32'(req_q.size()), 32'd0);
        chk("done_q_empty", 32'(done_q.size()), 32'd0);
        chk("mis_q_empty", 32'(mis_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
